// File: rtl/condicionador_pkg.sv
// State codes shared by the button conditioner and the HEX5 display path.
package condicionador_pkg;
  localparam logic [3:0] ESPERA      = 4'd0;
  localparam logic [3:0] FILTRA      = 4'd1;
  localparam logic [3:0] PRESSIONADO = 4'd2;
  localparam logic [3:0] SOLTA       = 4'd3;
endpackage

// File: rtl/sincronizador_2ff.sv
// Two-flop synchronizer for an asynchronous bus, async active-low reset.
module sincronizador_2ff #(
  parameter int WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;
endmodule

// File: rtl/condicionador_botoes.sv
// Button conditioner: synchronize, debounce, accept one press per release.
// Optional macro MULTIPLA_ERRO_EN rejects presses with more than one button set.
//
// state       | meaning
// ESPERA      | idle, no button seen
// FILTRA      | pattern seen, counting stable cycles
// PRESSIONADO | press accepted (or rejected), waiting for release
// SOLTA       | release seen, counting quiet cycles
module condicionador_botoes
  import condicionador_pkg::*;
#(
  parameter int N_BOTOES        = 4,
  parameter int DEBOUNCE_CICLOS = 50000,
  parameter int CW              = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [N_BOTOES-1:0] botoes,
  input  logic                limpa,
  output logic [N_BOTOES-1:0] jogada,
  output logic                jogada_feita,
  output logic                tem_jogada,
  output logic                erro_multipla,
  output logic [3:0]          db_estado
);
  logic [N_BOTOES-1:0] sb;
  logic [3:0]          estado_q, estado_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [N_BOTOES-1:0] amostra_q, amostra_d;
  logic [N_BOTOES-1:0] jogada_q, jogada_d;
  logic                feita_q, feita_d;
  logic                erro_q, erro_d;
  logic                fim_cnt;
  logic                multipla;

  sincronizador_2ff #(.WIDTH(N_BOTOES)) u_sync (
    .clk_i  (clock),
    .rst_n_i(reset),
    .d_i    (botoes),
    .q_o    (sb)
  );

  assign fim_cnt = (cnt_q == CW'(DEBOUNCE_CICLOS - 1));

`ifdef MULTIPLA_ERRO_EN
  assign multipla = |(amostra_q & (amostra_q - N_BOTOES'(1)));
`else
  assign multipla = 1'b0;
`endif

  always_comb begin
    estado_d  = estado_q;
    cnt_d     = cnt_q;
    amostra_d = amostra_q;
    jogada_d  = jogada_q;
    feita_d   = 1'b0;
    erro_d    = erro_q;
    case (estado_q)
      ESPERA: begin
        if (sb != '0) begin
          estado_d  = FILTRA;
          amostra_d = sb;
          cnt_d     = '0;
        end
      end
      FILTRA: begin
        if (sb == '0) begin
          estado_d = ESPERA;
          erro_d   = 1'b0;
        end else if (sb != amostra_q) begin
          amostra_d = sb;
          cnt_d     = '0;
        end else if (fim_cnt) begin
          estado_d = PRESSIONADO;
          if (multipla) begin
            erro_d = 1'b1;
          end else begin
            jogada_d = amostra_q;
            feita_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      PRESSIONADO: begin
        if (sb == '0) begin
          estado_d = SOLTA;
          cnt_d    = '0;
        end
      end
      SOLTA: begin
        if (sb != '0) begin
          estado_d = PRESSIONADO;
        end else if (fim_cnt) begin
          estado_d = ESPERA;
          erro_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        estado_d = ESPERA;
        erro_d   = 1'b0;
      end
    endcase
    // Clear wins over a same-cycle capture; the pulse still goes out.
    if (limpa) jogada_d = '0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q  <= ESPERA;
      cnt_q     <= '0;
      amostra_q <= '0;
      jogada_q  <= '0;
      feita_q   <= 1'b0;
      erro_q    <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      cnt_q     <= cnt_d;
      amostra_q <= amostra_d;
      jogada_q  <= jogada_d;
      feita_q   <= feita_d;
      erro_q    <= erro_d;
    end
  end

  assign jogada        = jogada_q;
  assign jogada_feita  = feita_q;
  assign tem_jogada    = |sb;
  assign erro_multipla = erro_q;
  assign db_estado     = estado_q;
endmodule
